// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^N) power engine.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default irreducible polynomials (MSB set) for N = 3..8.
  localparam logic [16:0] POLY_N3 = 17'h0000B;
  localparam logic [16:0] POLY_N4 = 17'h00013;
  localparam logic [16:0] POLY_N5 = 17'h00025;
  localparam logic [16:0] POLY_N6 = 17'h00043;
  localparam logic [16:0] POLY_N7 = 17'h00083;
  localparam logic [16:0] POLY_N8 = 17'h0011B;

  // Exponent that maps x to its multiplicative inverse: 2^n - 2.
  function automatic int unsigned inv_exponent(input int unsigned n);
    return (32'd1 << n) - 32'd2;
  endfunction

endpackage

// File: rtl/gf2n_power_engine_if.sv
// Operand/result valid-ready bus of the power engine.
interface gf2n_power_engine_if #(
  parameter int unsigned N = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_x;
  logic [N-1:0] in_e;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_y;

  modport master (
    output in_valid, in_x, in_e, in_inv, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, in_e, in_inv, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/gf2n_mul.sv
// Combinational GF(2^N) multiplier, polynomial basis, interleaved reduction.
module gf2n_mul #(
  parameter int unsigned N    = 6,
  parameter logic [N:0]  POLY = 7'h43
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_p
);

  logic [N-1:0] w_acc;
  logic [N-1:0] w_sh;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing a as it shifts.
  always_comb begin
    w_acc = '0;
    w_sh  = i_a;
    for (int i = 0; i < N; i++) begin
      if (i_b[i]) w_acc = w_acc ^ w_sh;
      w_sh = w_sh[N-1] ? ((w_sh << 1) ^ POLY[N-1:0]) : (w_sh << 1);
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/gf2n_power_engine.sv
// Iterative x^e / inverse engine over GF(2^N); one exponent bit per cycle, MSB first.
module gf2n_power_engine
  import gf_pkg::*;
#(
  parameter int unsigned N    = 6,
  parameter logic [N:0]  POLY = 7'h43
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gf2n_power_engine_if.slave     io_bus
);

  localparam int unsigned  CNT_W = $clog2(N);
  localparam logic [N-1:0] INV_E = N'(inv_exponent(N));

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_acc, w_acc_nxt;
  logic [N-1:0]     r_x, w_x_nxt;
  logic [N-1:0]     r_e, w_e_nxt;
  logic [N-1:0]     r_y, w_y_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]     w_sq;
  logic [N-1:0]     w_sqx;
  logic [N-1:0]     w_step;

  gf2n_mul #(.N(N), .POLY(POLY)) u_square (
    .i_a (r_acc),
    .i_b (r_acc),
    .o_p (w_sq)
  );

  gf2n_mul #(.N(N), .POLY(POLY)) u_cond_mul (
    .i_a (w_sq),
    .i_b (r_x),
    .o_p (w_sqx)
  );

  assign w_step = r_e[r_cnt] ? w_sqx : w_sq;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_x     <= '0;
      r_e     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_x     <= w_x_nxt;
      r_e     <= w_e_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and datapath update: capture, square-and-multiply, hold result.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_x_nxt     = r_x;
    w_e_nxt     = r_e;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (io_bus.in_valid) begin
          w_x_nxt     = io_bus.in_x;
          w_e_nxt     = io_bus.in_inv ? INV_E : io_bus.in_e;
          w_acc_nxt   = N'(1);
          w_cnt_nxt   = CNT_W'(N - 1);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_y_nxt     = w_step;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (io_bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = (r_state == DONE);
  assign io_bus.out_y     = r_y;

endmodule

// File: tb/tb_gf2n_power_engine.sv
// Self-checking bench for gf2n_power_engine (N=6, POLY=0x43).
module tb_gf2n_power_engine;

  localparam int N = 6;

  logic clk;
  logic rst_n;

  gf2n_power_engine_if #(.N(N)) bus ();

  gf2n_power_engine #(.N(N), .POLY(7'h43)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain polynomial product, then long-division reduction.
  function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
    int prod = 0;
    for (int i = 0; i < 6; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int bt = 10; bt >= 6; bt--) if (prod[bt]) prod = prod ^ (32'h43 << (bt - 6));
    return 6'(prod);
  endfunction

  // x^e by e repeated multiplications.
  function automatic logic [5:0] m_pow(input logic [5:0] x, input logic [5:0] e);
    logic [5:0] y = 6'h01;
    for (int i = 0; i < int'(e); i++) y = m_mul(y, x);
    return y;
  endfunction

  // Inverse by exhaustive search; 0 maps to 0.
  function automatic logic [5:0] m_inv(input logic [5:0] x);
    logic [5:0] cand;
    for (int y = 1; y < 64; y++) begin
      cand = 6'(y);
      if (m_mul(x, cand) == 6'h01) return cand;
    end
    return 6'h00;
  endfunction

  logic [5:0] exp_q[$];
  int         edge_q[$];
  logic [5:0] last_y;
  logic [5:0] held_y;
  logic       prev_valid;
  logic       sweep;
  int         sweep_cnt;
  int         last_acc_edge;

  // Acceptance monitor: each accepted operand enqueues its model result.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(bus.in_inv ? m_inv(bus.in_x) : m_pow(bus.in_x, bus.in_e));
      edge_q.push_back(cyc + 1);
      if (sweep) begin
        if (sweep_cnt > 0) chk("issue_interval", cyc + 1 - last_acc_edge, N + 2);
        sweep_cnt++;
      end
      last_acc_edge = cyc + 1;
    end
  end

  // Compare process: result value, latency, hold stability, no stale results.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      edge_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) chk("stale_result", 1, 0);
          else begin
            chk("result", int'(bus.out_y), int'(exp_q[0]));
            chk("latency", cyc - edge_q[0], N);
          end
          held_y = bus.out_y;
        end else begin
          chk("hold_out_y", int'(bus.out_y), int'(held_y));
        end
        if (bus.out_ready && exp_q.size() > 0) begin
          last_y = bus.out_y;
          void'(exp_q.pop_front());
          void'(edge_q.pop_front());
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [5:0] x, input logic [5:0] e, input logic inv,
                        input logic [5:0] lit, input string name);
    @(posedge clk); #1;
    bus.in_x = x; bus.in_e = e; bus.in_inv = inv; bus.in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();
    chk(name, int'(last_y), int'(lit));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    sweep = 1'b0; sweep_cnt = 0; last_acc_edge = 0;
    prev_valid = 1'b0; last_y = '0; held_y = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_e = '0; bus.in_inv = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_y", int'(bus.out_y), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Model pins.
    chk("model_pow_2_17", int'(m_pow(6'h02, 6'd17)), 'h26);
    chk("model_inv_2", int'(m_inv(6'h02)), 'h21);

    // Basic powers, inverse mode, boundary exponents.
    run_op(6'h02, 6'd6,  1'b0, 6'h03, "lit_2pow6");
    run_op(6'h02, 6'd17, 1'b0, 6'h26, "lit_2pow17");
    run_op(6'h02, 6'h15, 1'b1, 6'h21, "lit_inv2");
    run_op(6'h00, 6'h15, 1'b1, 6'h00, "lit_inv0");
    run_op(6'h00, 6'd0,  1'b0, 6'h01, "lit_0pow0");
    run_op(6'h02, 6'd63, 1'b0, 6'h01, "lit_2pow63");
    run_op(6'h01, 6'h2A, 1'b0, 6'h01, "lit_1pow2A");
    run_op(6'h00, 6'd63, 1'b0, 6'h00, "lit_0pow63");

    // Reset mid-RUN aborts the operation.
    @(posedge clk); #1;
    bus.in_x = 6'h02; bus.in_e = 6'd17; bus.in_inv = 1'b0; bus.in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_out_y", int'(bus.out_y), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    repeat (15) @(negedge clk);
    chk("abort_no_result", int'(bus.out_valid), 0);

    // Backpressure in DONE with a rejected concurrent operand.
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_x = 6'h03; bus.in_e = 6'd5; bus.in_inv = 1'b0; bus.in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; break; end
    end
    if (!seen) chk("bp_valid_timeout", 0, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus.in_valid = (k == 2);
      bus.in_x = 6'h07;
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_out_y", int'(bus.out_y), 'h33);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_ready", int'(bus.in_ready), 1);
    chk("bp_last_y", int'(last_y), 'h33);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Back-to-back sweep with in_valid held high.
    @(posedge clk); #1;
    sweep = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      bus.in_x   = 6'(i % 64);
      bus.in_inv = (i >= 64);
      bus.in_e   = (i >= 64) ? 6'h15 : 6'd17;
      wait_accept();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_drain();
    sweep = 1'b0;
    chk("sweep_count", sweep_cnt, 128);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2n_power_engine.md
Name: gf2n_power_engine

Overview:
- Iterative power-map engine over GF(2^N) in polynomial basis. Computes y = x^e for a run-time exponent e, or the field inverse when requested.
- Parametrised, sequential successor to the fixed-exponent combinational 6-bit power S-boxes.
- Sits between an operand source and a result sink using valid/ready handshakes on both sides.
- Intended for S-box exploration over many exponents and field sizes without regenerating RTL.

Parameters:
- N, 6, field width in bits; also the exponent width. Legal range 3..16.
- POLY, 7'h43, irreducible reduction polynomial, N+1 bits with the MSB set (default x^6+x+1).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  engine can accept an operand
- in_x  in  N  base element
- in_e  in  N  exponent, 0..2^N-1
- in_inv  in  1  1 = compute x^(2^N-2) (inverse, 0->0); in_e is ignored
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_y  out  N  result

Behaviour:
- Reset (async assert, sync-released by the environment) forces:
  - state=IDLE, in_ready=1, out_valid=0, out_y=0;
  - internal acc, x, e and cnt all cleared.
- A reset during RUN or DONE aborts the operation; no partial result is ever presented.
- States are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture:
    - xr=in_x;
    - er = in_inv ? (2^N-2) : in_e;
    - acc=1; cnt=N-1.
    - Then go to RUN.
  - RUN: one exponent bit per cycle, MSB first. Each cycle: acc <= er[cnt] ? (acc*acc)*xr : acc*acc, reduced mod POLY. cnt decrements. In the cycle where cnt==0, go to DONE.
  - DONE: out_valid=1, out_y=acc. out_y stays stable while out_valid&!out_ready. On out_ready, return to IDLE.
- in_ready is asserted only in IDLE and is a combinational decode of state. Operands are never accepted in RUN or DONE, even if out_ready is high in the same cycle.
- Latency: acceptance edge at cycle k gives RUN on edges k+1..k+N, and out_valid is visible after edge k+N.
  - Minimum issue interval is N+2 cycles (accept, N RUN cycles, DONE handshake).
- Arithmetic rules:
  - All arithmetic is carry-less. Products are reduced modulo POLY, so results are always N bits.
  - e=0 gives 1 for every x, including 0^0=1.
  - e=2^N-1 gives 1 for every x≠0 and 0 for x=0.
  - Inverse mode gives 0 for x=0.
- Latency is fixed and independent of the exponent value: leading zero bits are not skipped.
- out_y is a registered output. No combinational path exists from in_* to out_*.
- in_valid held high while in_ready=0 has no effect. Input fields may change freely at that time.
- out_ready asserted outside DONE is ignored.

Decomposition:
- Shared package gf_pkg holds:
  - state enum {IDLE,RUN,DONE};
  - the default POLY constants for N=3..8;
  - a function computing 2^N-2.
- One sub-module, gf2n_mul (combinational GF(2^N) multiply parameterised by N and POLY), instantiated twice:
  - square: acc*acc;
  - conditional multiply: square*xr.
- The FSM, the counter and the handshake stay in the top module.

Test Plan (N=6, POLY=0x43):
- Reset then idle: rst_n low mid-RUN (x=2, e=17) -> out_valid=0 and out_y=0 immediately; in_ready=1 after release; no stale result ever appears.
- Basic powers:
  - x=0x02, e=6 -> out_y=0x03, with out_valid exactly 6 cycles after acceptance;
  - x=0x02, e=17 -> out_y=0x26.
- Inverse mode:
  - x=0x02, in_inv=1, in_e=0x15 (ignored) -> out_y=0x21;
  - x=0x00, in_inv=1 -> 0x00.
- Boundary exponents:
  - x=0x00, e=0 -> 0x01;
  - x=0x02, e=63 -> 0x01;
  - x=0x01, e=0x2A -> 0x01.
- Backpressure: out_ready held low 5 cycles in DONE -> out_y and out_valid stable, in_ready=0 throughout, and a concurrent in_valid pulse is not accepted; out_ready=1 -> IDLE next cycle.
- Sweep against a reference model: all 64 x for e=17 and in_inv=1, back-to-back with in_valid always high -> every result matches the model, and the issue interval is exactly 8 cycles.
